// File: rtl/stream_hs_checker_pkg.sv
// Shared types and helpers for the valid/ready stream handshake checker.
// Error codes, FSM states and a width-generic saturating increment.
package stream_hs_checker_pkg;

    localparam int unsigned SAT_W = 64;

    typedef enum logic [1:0] {
        NONE        = 2'd0,
        VALID_DROP  = 2'd1,
        DATA_CHANGE = 2'd2,
        TIMEOUT     = 2'd3
    } err_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        DONE    = 2'd2,
        ERROR   = 2'd3
    } state_e;

    // Increment val, holding at the all-ones value of a width-bit counter.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                                 input int unsigned      width);
        logic [SAT_W-1:0] max_v;
        if (width >= SAT_W) begin
            max_v = {SAT_W{1'b1}};
        end else begin
            max_v = (64'd1 << width) - 64'd1;
        end
        if (val >= max_v) begin
            return max_v;
        end else begin
            return val + 64'd1;
        end
    endfunction

endpackage

// File: rtl/stream_hs_sat_cnt.sv
// Saturating counter with synchronous reset, clear, enable and freeze.
// Clear together with enable loads 1 (start of a new count run).
module stream_hs_sat_cnt
    import stream_hs_checker_pkg::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             frz_i,
    output logic [Width-1:0] cnt_o,
    output logic [Width-1:0] cnt_nxt_o
);

    logic [Width-1:0] cnt_r;
    logic [Width-1:0] cnt_nxt_s;

    // Next count: freeze holds, clear restarts, enable saturates upward.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (frz_i) begin
            cnt_nxt_s = cnt_r;
        end else if (clr_i) begin
            if (en_i) begin
                cnt_nxt_s = Width'(1'b1);
            end else begin
                cnt_nxt_s = '0;
            end
        end else if (en_i) begin
            cnt_nxt_s = Width'(sat_inc(SAT_W'(cnt_r), Width));
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign cnt_o     = cnt_r;
    assign cnt_nxt_o = cnt_nxt_s;

endmodule

// File: rtl/stream_hs_checker.sv
// Passive valid/ready stream observer: checks stability rules, counts transfers and stalls.
// Optional stall timeout error enabled by defining STREAM_HS_CHECKER_TIMEOUT_EN.
module stream_hs_checker
    import stream_hs_checker_pkg::*;
#(
    parameter type         data_t        = logic,
    parameter int unsigned NumHandshakes = 100,
    parameter int unsigned CntWidth      = 32,
    parameter int unsigned TimeoutCycles = 1000,
    parameter bit          StopOnError   = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                valid_i,
    input  logic                ready_i,
    input  data_t               data_i,
    output logic [CntWidth-1:0] hs_cnt_o,
    output logic [CntWidth-1:0] stall_max_o,
    output logic [CntWidth-1:0] err_cnt_o,
    output err_e                err_code_o,
    output logic                err_o,
    output logic                done_o
);

    state_e              state_r, state_nxt_s;
    logic                pend_r, pend_nxt_s;
    data_t               cap_r, cap_nxt_s;
    logic [CntWidth-1:0] stall_max_r;
    err_e                err_code_r;
    logic                err_r;
    logic                done_r;

    logic                rst_s;
    logic                frz_s;
    logic                hs_s;
    logic                err_ev_s;
    err_e                err_kind_s;
    logic                to_ev_s;
    logic                err_any_s;
    err_e                err_kind_any_s;
    logic                done_hit_s;
    logic                stall_clr_s;
    logic                stall_en_s;
    logic [CntWidth-1:0] hs_cnt_s, hs_cnt_nxt_s;
    logic [CntWidth-1:0] stall_s, stall_nxt_s;
    logic [CntWidth-1:0] err_cnt_s, unused_err_cnt_nxt_s;

    assign rst_s = rst_i | clear_i;

    stream_hs_sat_cnt #(.Width(CntWidth)) u_hs_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_s),
        .clr_i     (1'b0),
        .en_i      (hs_s),
        .frz_i     (frz_s),
        .cnt_o     (hs_cnt_s),
        .cnt_nxt_o (hs_cnt_nxt_s)
    );

    stream_hs_sat_cnt #(.Width(CntWidth)) u_stall_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_s),
        .clr_i     (stall_clr_s),
        .en_i      (stall_en_s),
        .frz_i     (frz_s),
        .cnt_o     (stall_s),
        .cnt_nxt_o (stall_nxt_s)
    );

    stream_hs_sat_cnt #(.Width(CntWidth)) u_err_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_s),
        .clr_i     (1'b0),
        .en_i      (err_any_s),
        .frz_i     (frz_s),
        .cnt_o     (err_cnt_s),
        .cnt_nxt_o (unused_err_cnt_nxt_s)
    );

    // Classify the sampled link into handshake, stall and protocol-error events.
    always_comb begin
        hs_s        = valid_i & ready_i;
        err_ev_s    = 1'b0;
        err_kind_s  = NONE;
        pend_nxt_s  = pend_r;
        cap_nxt_s   = cap_r;
        stall_clr_s = 1'b0;
        stall_en_s  = 1'b0;
        if (pend_r) begin
            if (!valid_i) begin
                err_ev_s    = 1'b1;
                err_kind_s  = VALID_DROP;
                pend_nxt_s  = 1'b0;
                stall_clr_s = 1'b1;
            end else if (data_i != cap_r) begin
                err_ev_s   = 1'b1;
                err_kind_s = DATA_CHANGE;
                if (ready_i) begin
                    pend_nxt_s  = 1'b0;
                    stall_clr_s = 1'b1;
                end else begin
                    cap_nxt_s  = data_i;
                    stall_en_s = 1'b1;
                end
            end else if (ready_i) begin
                pend_nxt_s  = 1'b0;
                stall_clr_s = 1'b1;
            end else begin
                stall_en_s = 1'b1;
            end
        end else begin
            if (valid_i && !ready_i) begin
                pend_nxt_s  = 1'b1;
                cap_nxt_s   = data_i;
                stall_clr_s = 1'b1;
                stall_en_s  = 1'b1;
            end else begin
                stall_clr_s = 1'b1;
            end
        end
    end

`ifdef STREAM_HS_CHECKER_TIMEOUT_EN
    logic to_fired_r, to_fired_nxt_s, to_armed_s;

    // One-shot stall timeout; re-armed whenever the stall run restarts.
    always_comb begin
        to_armed_s = 1'b0;
        if (stall_clr_s) begin
            to_armed_s = 1'b1;
        end else begin
            to_armed_s = ~to_fired_r;
        end
        to_ev_s        = stall_en_s & to_armed_s & ~err_ev_s &
                         (stall_nxt_s >= CntWidth'(TimeoutCycles));
        to_fired_nxt_s = ~to_armed_s | to_ev_s;
    end

    // Timeout one-shot flag.
    always_ff @(posedge clk_i) begin
        if (rst_s) begin
            to_fired_r <= 1'b0;
        end else if (!frz_s) begin
            to_fired_r <= to_fired_nxt_s;
        end else begin
            to_fired_r <= to_fired_r;
        end
    end
`else
    logic unused_timeout_s;
    assign unused_timeout_s = (TimeoutCycles == 32'd0);
    assign to_ev_s          = 1'b0;
`endif

    // Merge protocol and timeout errors; at most one error event per cycle.
    always_comb begin
        err_any_s = err_ev_s | to_ev_s;
        if (err_ev_s) begin
            err_kind_any_s = err_kind_s;
        end else begin
            err_kind_any_s = TIMEOUT;
        end
        done_hit_s = hs_s & (hs_cnt_nxt_s >= CntWidth'(NumHandshakes));
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_s) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: ERROR outranks DONE, which outranks the pending status.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ERROR: state_nxt_s = ERROR;
            IDLE, PENDING, DONE: begin
                if (err_any_s && StopOnError) begin
                    state_nxt_s = ERROR;
                end else if (done_r || done_hit_s) begin
                    state_nxt_s = DONE;
                end else if (pend_nxt_s) begin
                    state_nxt_s = PENDING;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State-decoded controls.
    always_comb begin
        frz_s = 1'b0;
        case (state_r)
            ERROR:   frz_s = 1'b1;
            default: frz_s = 1'b0;
        endcase
    end

    // Pending payload, stall maximum and sticky status flags.
    always_ff @(posedge clk_i) begin
        if (rst_s) begin
            pend_r      <= 1'b0;
            cap_r       <= '0;
            stall_max_r <= '0;
            err_code_r  <= NONE;
            err_r       <= 1'b0;
            done_r      <= 1'b0;
        end else if (!frz_s) begin
            pend_r <= pend_nxt_s;
            cap_r  <= cap_nxt_s;
            if (stall_nxt_s > stall_max_r) begin
                stall_max_r <= stall_nxt_s;
            end else begin
                stall_max_r <= stall_max_r;
            end
            if (err_any_s) begin
                err_r <= 1'b1;
                if (err_code_r == NONE) begin
                    err_code_r <= err_kind_any_s;
                end else begin
                    err_code_r <= err_code_r;
                end
            end else begin
                err_r      <= err_r;
                err_code_r <= err_code_r;
            end
            done_r <= done_r | done_hit_s;
        end else begin
            pend_r      <= pend_r;
            cap_r       <= cap_r;
            stall_max_r <= stall_max_r;
            err_code_r  <= err_code_r;
            err_r       <= err_r;
            done_r      <= done_r;
        end
    end

    assign hs_cnt_o    = hs_cnt_s;
    assign stall_max_o = stall_max_r;
    assign err_cnt_o   = err_cnt_s;
    assign err_code_o  = err_code_r;
    assign err_o       = err_r;
    assign done_o      = done_r;

endmodule

// File: tb/tb_stream_hs_checker.sv
// Directed bench for stream_hs_checker: one StopOnError=1 and one StopOnError=0 instance on a shared link.
module tb_stream_hs_checker;
    import stream_hs_checker_pkg::*;

    typedef logic [7:0] byte_t;

    logic  clk, rst, clear, valid, ready;
    byte_t data;

    logic [31:0] a_hs, a_smax, a_ecnt;
    err_e        a_code;
    logic        a_err, a_done;
    logic [7:0]  b_hs, b_smax, b_ecnt;
    err_e        b_code;
    logic        b_err, b_done;

    int n_chk;
    int n_err;

    stream_hs_checker #(
        .data_t(byte_t), .NumHandshakes(100), .CntWidth(32),
        .TimeoutCycles(16), .StopOnError(1'b1)
    ) u_stop (
        .clk_i(clk), .rst_i(rst), .clear_i(clear),
        .valid_i(valid), .ready_i(ready), .data_i(data),
        .hs_cnt_o(a_hs), .stall_max_o(a_smax), .err_cnt_o(a_ecnt),
        .err_code_o(a_code), .err_o(a_err), .done_o(a_done)
    );

    stream_hs_checker #(
        .data_t(byte_t), .NumHandshakes(4), .CntWidth(8),
        .TimeoutCycles(16), .StopOnError(1'b0)
    ) u_cont (
        .clk_i(clk), .rst_i(rst), .clear_i(clear),
        .valid_i(valid), .ready_i(ready), .data_i(data),
        .hs_cnt_o(b_hs), .stall_max_o(b_smax), .err_cnt_o(b_ecnt),
        .err_code_o(b_code), .err_o(b_err), .done_o(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic r, input byte_t d);
        valid = v;
        ready = r;
        data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear(input logic v, input logic r, input byte_t d);
        clear = 1'b1;
        cyc(v, r, d);
        clear = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1'b1;
        clear = 1'b0;
        valid = 1'b0;
        ready = 1'b0;
        data  = 8'h00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_a_hs",   a_hs,   64'd0);
        chk("rst_a_smax", a_smax, 64'd0);
        chk("rst_a_ecnt", a_ecnt, 64'd0);
        chk("rst_a_code", a_code, 64'd0);
        chk("rst_a_err",  a_err,  64'd0);
        chk("rst_a_done", a_done, 64'd0);
        chk("rst_b_hs",   b_hs,   64'd0);
        rst = 1'b0;

        // back-to-back handshakes: done timing and counter saturation
        for (int i = 0; i < 260; i++) begin
            cyc(1'b1, 1'b1, byte_t'(i));
            if (i == 2)   chk("b_done_pre",  b_done, 64'd0);
            if (i == 3)   chk("b_done_at4",  b_done, 64'd1);
            if (i == 98)  chk("a_done_pre",  a_done, 64'd0);
            if (i == 98)  chk("a_hs_99",     a_hs,   64'd99);
            if (i == 99)  chk("a_done_100",  a_done, 64'd1);
            if (i == 99)  chk("a_hs_100",    a_hs,   64'd100);
            if (i == 99)  chk("a_err_100",   a_err,  64'd0);
            if (i == 99)  chk("a_smax_100",  a_smax, 64'd0);
            if (i == 254) chk("b_hs_sat",    b_hs,   64'd255);
        end
        chk("a_hs_260",  a_hs,  64'd260);
        chk("b_hs_hold", b_hs,  64'd255);
        chk("b_err_hs",  b_err, 64'd0);
        cyc(1'b0, 1'b0, 8'h00);
        pulse_clear(1'b0, 1'b0, 8'h00);
        chk("clr_a_hs",   a_hs,   64'd0);
        chk("clr_a_done", a_done, 64'd0);
        chk("clr_b_done", b_done, 64'd0);

        // 7-cycle stall then handshake
        repeat (7) cyc(1'b1, 1'b0, 8'hA5);
        chk("stall_a_hs0",  a_hs,   64'd0);
        chk("stall_a_smax", a_smax, 64'd7);
        cyc(1'b1, 1'b1, 8'hA5);
        chk("stall_a_hs1",  a_hs,   64'd1);
        chk("stall_a_max7", a_smax, 64'd7);
        chk("stall_a_err",  a_err,  64'd0);
        chk("stall_b_max7", b_smax, 64'd7);
        chk("stall_b_err",  b_err,  64'd0);
        cyc(1'b0, 1'b0, 8'h00);
        pulse_clear(1'b0, 1'b0, 8'h00);

        // valid dropped after 3 stall cycles
        repeat (3) cyc(1'b1, 1'b0, 8'h11);
        chk("drop_a_err_pre", a_err, 64'd0);
        cyc(1'b0, 1'b0, 8'h11);
        chk("drop_a_err",  a_err,  64'd1);
        chk("drop_a_code", a_code, 64'd1);
        chk("drop_a_ecnt", a_ecnt, 64'd1);
        chk("drop_a_smax", a_smax, 64'd3);
        chk("drop_b_code", b_code, 64'd1);
        chk("drop_b_ecnt", b_ecnt, 64'd1);
        repeat (2) cyc(1'b1, 1'b1, 8'h22);
        chk("drop_a_frozen", a_hs,   64'd0);
        chk("drop_b_hs2",    b_hs,   64'd2);
        chk("drop_a_ecnt1",  a_ecnt, 64'd1);
        pulse_clear(1'b0, 1'b0, 8'h00);
        chk("clr_err_a_err",  a_err,  64'd0);
        chk("clr_err_a_code", a_code, 64'd0);

        // payload change while stalled
        repeat (2) cyc(1'b1, 1'b0, 8'h3C);
        cyc(1'b1, 1'b0, 8'h3D);
        chk("chg_b_code", b_code, 64'd2);
        chk("chg_b_ecnt", b_ecnt, 64'd1);
        chk("chg_b_hs0",  b_hs,   64'd0);
        chk("chg_b_smax", b_smax, 64'd3);
        cyc(1'b1, 1'b1, 8'h3D);
        chk("chg_b_hs1",   b_hs,   64'd1);
        chk("chg_b_ecnt1", b_ecnt, 64'd1);
        chk("chg_a_hs0",   a_hs,   64'd0);
        chk("chg_a_code",  a_code, 64'd2);
        cyc(1'b1, 1'b0, 8'h40);
        cyc(1'b0, 1'b0, 8'h40);
        chk("chg_b_ecnt2", b_ecnt, 64'd2);
        chk("chg_b_first", b_code, 64'd2);
        chk("chg_a_ecnt1", a_ecnt, 64'd1);
        pulse_clear(1'b0, 1'b0, 8'h00);

        // error on the 100th handshake: ERROR and DONE together
        for (int i = 0; i < 99; i++) cyc(1'b1, 1'b1, byte_t'(i));
        cyc(1'b1, 1'b0, 8'h55);
        cyc(1'b1, 1'b1, 8'h56);
        chk("prec_a_hs",   a_hs,   64'd100);
        chk("prec_a_done", a_done, 64'd1);
        chk("prec_a_err",  a_err,  64'd1);
        chk("prec_a_code", a_code, 64'd2);
        chk("prec_b_ecnt", b_ecnt, 64'd1);
        cyc(1'b1, 1'b1, 8'h57);
        chk("prec_a_frozen", a_hs, 64'd100);
        chk("prec_b_hs",     b_hs, 64'd101);
        pulse_clear(1'b0, 1'b0, 8'h00);

        // clear in the middle of a stall after 50 handshakes
        for (int i = 0; i < 50; i++) cyc(1'b1, 1'b1, byte_t'(i));
        chk("mid_a_hs50", a_hs, 64'd50);
        repeat (2) cyc(1'b1, 1'b0, 8'h99);
        pulse_clear(1'b1, 1'b0, 8'h99);
        chk("mid_a_hs0",   a_hs,   64'd0);
        chk("mid_a_smax",  a_smax, 64'd0);
        chk("mid_a_err",   a_err,  64'd0);
        chk("mid_a_code",  a_code, 64'd0);
        chk("mid_b_done",  b_done, 64'd0);
        chk("mid_b_hs0",   b_hs,   64'd0);
        cyc(1'b1, 1'b1, 8'h99);
        chk("mid_a_hs1",  a_hs,  64'd1);
        chk("mid_a_err1", a_err, 64'd0);
        chk("mid_b_hs1",  b_hs,  64'd1);
        cyc(1'b0, 1'b0, 8'h00);
        pulse_clear(1'b0, 1'b0, 8'h00);

        // 20-cycle stall: timeout at the 16th cycle when enabled
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b0, 8'h77);
`ifdef STREAM_HS_CHECKER_TIMEOUT_EN
            if (i == 14) chk("to_a_err_pre", a_err,  64'd0);
            if (i == 15) chk("to_a_code",    a_code, 64'd3);
            if (i == 15) chk("to_a_ecnt",    a_ecnt, 64'd1);
`endif
        end
`ifdef STREAM_HS_CHECKER_TIMEOUT_EN
        chk("to_b_ecnt", b_ecnt, 64'd1);
        chk("to_b_code", b_code, 64'd3);
        chk("to_a_smax", a_smax, 64'd16);
        chk("to_b_smax", b_smax, 64'd20);
`else
        chk("long_a_err",  a_err,  64'd0);
        chk("long_b_err",  b_err,  64'd0);
        chk("long_a_smax", a_smax, 64'd20);
        chk("long_b_smax", b_smax, 64'd20);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/stream_hs_checker.md
# stream_hs_checker

Passive, synthesizable observer for a valid/ready stream; the receiving-side counterpart to the random stream drivers used in benches. It samples a link every clock, checks the handshake stability rules, counts completed transfers and stall lengths, and raises `done_o` after a configured number of handshakes. It sits in parallel with any master/slave pair and never drives the link.

## Interface
- `data_t`, default `logic`: payload type observed on `data_i`.
- `NumHandshakes`, default 100: handshake count at which `done_o` asserts.
- `CntWidth`, default 32: width of all counters.
- `TimeoutCycles`, default 1000: maximum consecutive stall cycles before a timeout error (timeout feature only).
- `StopOnError`, default 1: 1 = freeze in ERROR on the first error; 0 = keep monitoring.
- `clk_i` in 1: clock, all logic on the rising edge.
- `rst_i` in 1: reset, synchronous and active-high.
- `clear_i` in 1: synchronous soft clear, same effect as reset.
- `valid_i` in 1: observed valid.
- `ready_i` in 1: observed ready.
- `data_i` in `$bits(data_t)`: observed payload.
- `hs_cnt_o` out `CntWidth`: completed handshakes.
- `stall_max_o` out `CntWidth`: longest stall observed (cycles of valid high and ready low).
- `err_cnt_o` out `CntWidth`: number of error events.
- `err_code_o` out 2: first error code, of type `err_e`.
- `err_o` out 1: sticky error flag.
- `done_o` out 1: sticky, `hs_cnt_o` has reached `NumHandshakes`.

## Operation
- FSM `state_e` has four states:
  - IDLE: no transfer pending.
  - PENDING: valid seen without ready; payload captured.
  - DONE: target reached; monitoring continues.
  - ERROR: reached only when `StopOnError` = 1.
- Each cycle the checker samples `valid_i`, `ready_i` and `data_i`.
- `valid_i & ready_i` is a handshake. `hs_cnt_o` increments by 1, the stall counter zeroes, and IDLE or PENDING goes to IDLE.
- `valid_i & ~ready_i` in IDLE captures `data_i`, goes to PENDING and sets the stall counter to 1.
- In PENDING:
  - `~valid_i` is error VALID_DROP (code 1).
  - `valid_i` with `data_i` differing from the captured payload is error DATA_CHANGE (code 2).
  - If both apply, VALID_DROP wins.
  - A handshake whose data differs from the captured payload is DATA_CHANGE and still counts as a handshake.
- The stall counter increments on every non-handshake PENDING cycle. `stall_max_o` is updated to max(stall_max, stall).
- Error event:
  - `err_o` sets and `err_cnt_o` increments.
  - `err_code_o` latches only if it is currently NONE (0).
  - With `StopOnError` = 1, go to ERROR; all counters freeze until reset or clear.
  - With `StopOnError` = 0, go to IDLE (VALID_DROP) or stay PENDING with a recaptured payload (DATA_CHANGE).
- When `hs_cnt_o` reaches `NumHandshakes`, enter DONE. In DONE, handshakes and errors keep being tracked as in IDLE/PENDING; the pending status is kept in a separate flag. An error in DONE goes to ERROR if `StopOnError` = 1.
- Precedence: ERROR over DONE. If the error and the `NumHandshakes`-th handshake occur in the same cycle, the result is `err_o` = 1, `done_o` = 1 and the state is ERROR.
- All counters saturate at all-ones and never wrap.
- `rst_i` and `clear_i`: `rst_i` has priority, but the effect is identical. State is IDLE, all counters 0, `err_code_o` = NONE, `err_o` = 0, `done_o` = 0. Both are legal mid-transfer; a pending transfer is discarded.

## Timing
- All outputs are registered and are 0 in the cycle after reset.
- Output latency: every output reflects a sample one cycle after the sampling edge.
  - `hs_cnt_o` shows N+1 the cycle after the handshake edge.
  - `err_o` asserts the cycle after the offending edge.
- `done_o` asserts the cycle after the `NumHandshakes`-th handshake edge.
- No combinational path exists from any input to any output.
- `ready_i` alone, without `valid_i`, is never an error. `ready_i` may toggle freely.

## Configuration
- `STREAM_HS_CHECKER_TIMEOUT_EN` defined:
  - Error TIMEOUT (code 3) fires when the stall counter reaches `TimeoutCycles`.
  - It is a one-shot per pending transfer and follows the normal error rules.
- Not defined: there is no timeout logic, code 3 never occurs, and `TimeoutCycles` is unused.

## Structure
- Package `stream_hs_checker_pkg` holds:
  - `err_e` (NONE=0, VALID_DROP=1, DATA_CHANGE=2, TIMEOUT=3).
  - `state_e`.
  - A saturating-increment function.
- One sub-module, `stream_hs_sat_cnt`: a parameterized saturating counter with synchronous clear, enable and freeze. It is instantiated for the handshake, stall and error counters.

## Test plan
- 100 handshakes, `valid_i` = `ready_i` = 1 with incrementing data -> `done_o` = 1 exactly one cycle after the 100th edge; `hs_cnt_o` = 100, `err_o` = 0, `stall_max_o` = 0.
- `valid_i` high with data 0xA5, `ready_i` low for 7 cycles, then high -> `hs_cnt_o` = 1, `stall_max_o` = 7, no error.
- `valid_i` high for 3 stall cycles, then dropped without ready -> `err_o` = 1, `err_code_o` = 1, `err_cnt_o` = 1; with `StopOnError` = 1, later handshakes leave `hs_cnt_o` frozen.
- Data changes from 0x3C to 0x3D while stalled, `StopOnError` = 0 -> `err_code_o` = 2, `err_cnt_o` = 1; the following handshake increments `hs_cnt_o`.
- Macro defined, `TimeoutCycles` = 16, `valid_i` high and `ready_i` low for 20 cycles -> `err_code_o` = 3 one cycle after the 16th stall cycle, with `err_cnt_o` = 1 only.
- `clear_i` pulsed mid-stall after 50 handshakes -> the next cycle shows all outputs 0 and state IDLE; the following handshake gives `hs_cnt_o` = 1.
